spi_reg_host: RTL

//  SPI master driving the board's 16-bit word-framed register protocol. Turns single-register writes and

---
 rtl/spi_reg_host.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_reg_host.sv
// spi_reg_host: SPI master for the 16-bit word-framed register protocol (single writes, burst reads).
// Optional build macro SPI_HOST_SIGCHK_EN: check register 0 against signature 16'h4A53 (sticky sig_err).
module spi_reg_host #(
   parameter int CLK_DIV = 4,
   parameter int GAP_CYC = 8,
   parameter int LEN_W   = 6
) (
   input  logic             SYS_CLK,
   input  logic             SYS_RST,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_write,
   input  logic [9:0]       cmd_addr,
   input  logic [15:0]      cmd_wdata,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             rd_valid,
   output logic [15:0]      rd_data,
   output logic             rd_last,
   output logic             done,
   output logic             sig_err,
   output logic             SPI_CLK,
   output logic             SSEL,
   output logic             MOSI,
   input  logic             MISO
);
   localparam int MAXC = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
   localparam int CW   = $clog2(MAXC);
   localparam int FW   = LEN_W + 1;
   localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_END = CW'(GAP_CYC - 1);
   localparam logic [15:0]   RD_REQ  = 16'h8000;

   typedef enum logic [2:0] {IDLE, LEAD, LOW, HIGH, TRAIL, GAP, DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   div_q, div_d;
   logic [3:0]      bit_q, bit_d;
   logic [FW-1:0]   frm_q, frm_d;
   logic [FW-1:0]   last_q, last_d;
   logic            is_wr_q, is_wr_d;
   logic [15:0]     wdata_q, wdata_d;
   logic [15:0]     tx_q, tx_d;
   logic [14:0]     rx_q, rx_d;
   logic [1:0]      miso_sync;
   logic [15:0]     rx_word;
   logic            rd_valid_d, rd_last_d;
   logic            in_frame_d;

   assign cmd_ready = (state_q == IDLE) && !SYS_RST;
   assign done      = (state_q == DONE);
   assign MOSI      = tx_q[15];
   assign rx_word   = {rx_q, miso_sync[1]};

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      bit_d      = bit_q;
      frm_d      = frm_q;
      last_d     = last_q;
      is_wr_d    = is_wr_q;
      wdata_d    = wdata_q;
      tx_d       = tx_q;
      rx_d       = rx_q;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               state_d = LEAD;
               div_d   = '0;
               frm_d   = '0;
               is_wr_d = cmd_write;
               wdata_d = cmd_wdata;
               // last frame index: 1 for a write, N for a read (N reads + closing 0000 frame)
               last_d  = cmd_write ? FW'(1)
                                   : ((cmd_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cmd_len});
               tx_d    = cmd_write ? {2'b01, 4'b0000, cmd_addr} : RD_REQ;
            end
         end
         LEAD: begin
            if (div_q == DIV_END) begin
               state_d = LOW;
               div_d   = '0;
               bit_d   = 4'd15;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         LOW: begin
            if (div_q == DIV_END) begin
               state_d = HIGH;
               div_d   = '0;
               rx_d    = rx_word[14:0];
               tx_d    = {tx_q[14:0], 1'b0};
               if (bit_q == '0 && !is_wr_q && frm_q != '0) begin
                  rd_valid_d = 1'b1;
                  rd_last_d  = (frm_q == last_q);
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         HIGH: begin
            if (div_q == DIV_END) begin
               div_d = '0;
               if (bit_q == '0) begin
                  state_d = TRAIL;
               end else begin
                  state_d = LOW;
                  bit_d   = bit_q - 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         TRAIL: begin
            if (div_q == DIV_END) begin
               state_d = GAP;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         GAP: begin
            if (div_q == GAP_END) begin
               div_d = '0;
               if (frm_q == last_q) begin
                  state_d = DONE;
               end else begin
                  state_d = LEAD;
                  frm_d   = frm_q + 1'b1;
                  if (is_wr_q) begin
                     tx_d = wdata_q;
                  end else begin
                     tx_d = (frm_d == last_q) ? 16'h0000 : RD_REQ;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      in_frame_d = (state_d == LEAD) || (state_d == LOW) || (state_d == HIGH) || (state_d == TRAIL);
   end

   // Pin outputs are registered from the next state so SSEL/SPI_CLK never glitch.
   always_ff @(posedge SYS_CLK) begin
      if (SYS_RST) begin
         state_q   <= IDLE;
         div_q     <= '0;
         bit_q     <= '0;
         frm_q     <= '0;
         last_q    <= '0;
         is_wr_q   <= 1'b0;
         wdata_q   <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
         miso_sync <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         rd_last   <= 1'b0;
         SSEL      <= 1'b1;
         SPI_CLK   <= 1'b1;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         bit_q     <= bit_d;
         frm_q     <= frm_d;
         last_q    <= last_d;
         is_wr_q   <= is_wr_d;
         wdata_q   <= wdata_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         miso_sync <= {miso_sync[0], MISO};
         rd_valid  <= rd_valid_d;
         rd_last   <= rd_last_d;
         if (rd_valid_d) begin
            rd_data <= rx_word;
         end
         SSEL      <= !in_frame_d;
         SPI_CLK   <= (state_d != LOW);
      end
   end

`ifdef SPI_HOST_SIGCHK_EN
   localparam logic [15:0] SIG_WORD = 16'h4A53;

   always_ff @(posedge SYS_CLK) begin
      if (SYS_RST) begin
         sig_err <= 1'b0;
      end else if (rd_valid_d && frm_q == FW'(1) && rx_word != SIG_WORD) begin
         sig_err <= 1'b1;
      end
   end
`else
   assign sig_err = 1'b0;
`endif

endmodule
